// File: rtl/fht_result_reader.sv
// fht_result_reader: streams the FHT core's four-bank result out as a single valid/ready word stream
module fht_result_reader #(
  parameter int D_BIT = 16,
  parameter int A_BIT = 8
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iSTART,
  output logic [A_BIT-1:0]   oADDR_RD_0,
  output logic [A_BIT-1:0]   oADDR_RD_1,
  output logic [A_BIT-1:0]   oADDR_RD_2,
  output logic [A_BIT-1:0]   oADDR_RD_3,
  input  logic [D_BIT-1:0]   iDATA_0,
  input  logic [D_BIT-1:0]   iDATA_1,
  input  logic [D_BIT-1:0]   iDATA_2,
  input  logic [D_BIT-1:0]   iDATA_3,
  output logic [D_BIT-1:0]   oDATA,
  output logic               oVALID,
  input  logic               iREADY,
  output logic [A_BIT+1:0]   oINDEX,
  output logic               oLAST,
  output logic               oBUSY,
  output logic               oDONE
);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, EMIT} state_t;
  state_t state, stateNext;
  logic startD;
  logic [A_BIT-1:0] addr, group;
  logic [1:0] beat;
  logic [D_BIT-1:0] bufWord [4];
  logic accept, groupEnd, lastGroup;
  assign accept = oVALID & iREADY;
  assign groupEnd = accept & (beat == 2'd3);
  assign lastGroup = group == {A_BIT{1'b1}};
  assign oVALID = state == EMIT;
  assign oBUSY = state != IDLE;
  assign oLAST = oVALID & lastGroup & (beat == 2'd3);
  assign oDATA = bufWord[beat];
  assign oINDEX = {group, beat};
  assign oADDR_RD_0 = addr;
  assign oADDR_RD_1 = addr;
  assign oADDR_RD_2 = addr;
  assign oADDR_RD_3 = addr;
  // next state: only a fresh rising start edge in IDLE launches a read-out
  always_comb begin
    stateNext = state;
    stateNext = state == IDLE  ? ((iSTART & !startD) ? FETCH : IDLE) :
                state == FETCH ? LOAD :
                state == LOAD  ? EMIT :
                (groupEnd & lastGroup) ? IDLE : EMIT;
  end
  // state register and start edge history
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state <= IDLE;
      startD <= 1'b0;
    end else begin
      state <= stateNext;
      startD <= iSTART;
    end
  end
  // address, group buffer and beat counter; the next group is fetched while the current one drains
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      addr <= '0;
      group <= '0;
      beat <= 2'd0;
      bufWord <= '{default: '0};
      oDONE <= 1'b0;
    end else begin
      oDONE <= groupEnd & lastGroup;
      if (state == IDLE || state == FETCH) addr <= '0;
      if (state == LOAD) begin
        bufWord <= '{iDATA_0, iDATA_1, iDATA_2, iDATA_3};
        addr <= addr + 1'b1;
        group <= '0;
        beat <= 2'd0;
      end
      if (accept) beat <= beat + 2'd1;
      if (groupEnd) begin
        bufWord <= '{iDATA_0, iDATA_1, iDATA_2, iDATA_3};
        group <= group + 1'b1;
        addr <= lastGroup ? '0 : addr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fht_result_reader.sv
// tb_fht_result_reader: directed scoreboard bench for the FHT result reader with a registered four-bank RAM model
module tb_fht_result_reader;
  localparam int D_BIT = 16;
  localparam int A_BIT = 2;
  localparam int N = 4 << A_BIT;
  logic iCLK = 1'b0;
  logic iRESET, iSTART, iREADY;
  logic [A_BIT-1:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
  logic [D_BIT-1:0] iDATA_0, iDATA_1, iDATA_2, iDATA_3, oDATA;
  logic oVALID, oLAST, oBUSY, oDONE;
  logic [A_BIT+1:0] oINDEX;
  int total = 0;
  int bad = 0;
  int expData[$];
  int expIdx[$];
  int cycles;

  fht_result_reader #(.D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
    .oADDR_RD_0(oADDR_RD_0), .oADDR_RD_1(oADDR_RD_1), .oADDR_RD_2(oADDR_RD_2), .oADDR_RD_3(oADDR_RD_3),
    .iDATA_0(iDATA_0), .iDATA_1(iDATA_1), .iDATA_2(iDATA_2), .iDATA_3(iDATA_3),
    .oDATA(oDATA), .oVALID(oVALID), .iREADY(iREADY), .oINDEX(oINDEX),
    .oLAST(oLAST), .oBUSY(oBUSY), .oDONE(oDONE)
  );

  always #5 iCLK = ~iCLK;

  // registered bank RAMs: bank b at address a holds 16*b+a
  always @(posedge iCLK) begin
    iDATA_0 <= 16'd0 + 16'(oADDR_RD_0);
    iDATA_1 <= 16'd16 + 16'(oADDR_RD_1);
    iDATA_2 <= 16'd32 + 16'(oADDR_RD_2);
    iDATA_3 <= 16'd48 + 16'(oADDR_RD_3);
  end

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic pushStream();
    for (int n = 0; n < N; n++) begin
      expData.push_back(16 * (n % 4) + n / 4);
      expIdx.push_back(n);
    end
  endtask

  // called at a negedge with iSTART low; leaves us at the negedge of the first valid word
  task automatic startEdge(input bit keep);
    iSTART = 1'b1;
    pushStream();
    @(negedge iCLK);
    chk("fetchBusy", oBUSY, 1);
    chk("fetchValid", oVALID, 0);
    chk("fetchAddr", oADDR_RD_0, 0);
    if (!keep) iSTART = 1'b0;
    @(negedge iCLK);
    chk("loadBusy", oBUSY, 1);
    chk("loadValid", oVALID, 0);
    @(negedge iCLK);
    chk("firstValid", oVALID, 1);
    chk("firstIdx", oINDEX, 0);
  endtask

  task automatic drain(input int pct, input bit toggle, input int stopAfter, output int cyc);
    bit lastAcc = 0;
    bit stalled = 0;
    bit finished = 0;
    bit stop = 0;
    logic [D_BIT-1:0] pd;
    logic [A_BIT+1:0] pi;
    logic [A_BIT-1:0] pa, ea;
    int acc = 0;
    int ed, ei;
    cyc = 0;
    while (cyc < 400 && !stop) begin
      cyc++;
      chk("done", oDONE, lastAcc);
      chk("busy", oBUSY, !lastAcc);
      if (lastAcc) begin
        finished = 1;
        stop = 1;
      end else begin
        chk("addrEq", {oADDR_RD_1, oADDR_RD_2, oADDR_RD_3}, {3{oADDR_RD_0}});
        if (stalled) begin
          chk("holdData", oDATA, pd);
          chk("holdIdx", oINDEX, pi);
          chk("holdAddr", oADDR_RD_0, pa);
        end
        if (oVALID) begin
          ea = oINDEX[A_BIT+1:2] + 1'b1;
          chk("addrAhead", oADDR_RD_0, ea);
        end
        if (toggle) iSTART = (cyc == 5);
        iREADY = ($urandom_range(99) < pct);
        stalled = oVALID && !iREADY;
        pd = oDATA;
        pi = oINDEX;
        pa = oADDR_RD_0;
        if (oVALID && iREADY) begin
          if (expData.size() == 0) chk("extraWord", expData.size(), 1);
          else begin
            ed = expData.pop_front();
            ei = expIdx.pop_front();
            chk("data", oDATA, ed);
            chk("index", oINDEX, ei);
            chk("lastTag", oLAST, ei == N - 1);
            lastAcc = (ei == N - 1);
            acc++;
            if (acc == stopAfter) begin
              finished = 1;
              stop = 1;
            end
          end
        end
        if (!stop) @(negedge iCLK);
      end
    end
    chk("finished", finished, 1);
    iREADY = 1'b1;
  endtask

  task automatic idleCheck(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge iCLK);
      chk("idleBusy", oBUSY, 0);
      chk("idleDone", oDONE, 0);
      chk("idleValid", oVALID, 0);
    end
  endtask

  initial begin
    iRESET = 1'b1;
    iSTART = 1'b0;
    iREADY = 1'b0;
    repeat (2) @(negedge iCLK);
    chk("rstValid", oVALID, 0);
    chk("rstLast", oLAST, 0);
    chk("rstBusy", oBUSY, 0);
    chk("rstDone", oDONE, 0);
    chk("rstAddr", {oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3}, 0);
    chk("rstIndex", oINDEX, 0);
    chk("rstData", oDATA, 0);
    iRESET = 1'b0;
    iREADY = 1'b1;
    @(negedge iCLK);
    // basic full-rate stream: 16 words then oDONE on the very next cycle
    startEdge(0);
    drain(100, 0, -1, cycles);
    chk("streamCycles", cycles, N + 1);
    idleCheck(3);
    // random backpressure
    startEdge(0);
    drain(50, 0, -1, cycles);
    chk("queueEmpty", expData.size(), 0);
    idleCheck(2);
    // level start held through and past the read-out gives one read-out only
    startEdge(1);
    drain(100, 0, -1, cycles);
    idleCheck(8);
    iSTART = 1'b0;
    @(negedge iCLK);
    // a new rising edge restarts; an extra edge during EMIT is ignored
    startEdge(0);
    drain(100, 1, -1, cycles);
    idleCheck(8);
    // reset after 6 accepted words abandons the transfer
    startEdge(0);
    drain(100, 0, 6, cycles);
    @(negedge iCLK);
    iRESET = 1'b1;
    expData.delete();
    expIdx.delete();
    @(negedge iCLK);
    chk("midRstValid", oVALID, 0);
    chk("midRstBusy", oBUSY, 0);
    chk("midRstAddr", oADDR_RD_0, 0);
    chk("midRstDone", oDONE, 0);
    iRESET = 1'b0;
    idleCheck(4);
    startEdge(0);
    drain(100, 0, -1, cycles);
    // back-to-back: start edge sampled on the cycle right after oDONE
    startEdge(0);
    drain(100, 0, -1, cycles);
    chk("b2bCycles", cycles, N + 1);
    idleCheck(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
